blake2b_ctrl: RTL and testbench

- Sequences the BLAKE2b compression core over a multi-block message.
- Owns the chaining value h, the 128-bit byte counter t and the final-block flag. Zero-pads the last block.
- Issues one start per block to the core and waits for its result.
- Presents the finished digest on a valid/ready output. Sits between the message-block source and the compression core.

---
 rtl/blake2b_ctrl_if.sv | 33 +++
 rtl/blake2b_ctrl.sv | 146 ++++++++++++++
 tb/tb_blake2b_ctrl.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blake2b_ctrl_if.sv
// Block-source, compression-core and digest buses of the BLAKE2b controller.
// slave = controller side, master = environment side (source, core, consumer).
interface blake2b_ctrl_if #(parameter int W = 64);
  logic              blk_valid_i;
  logic              blk_ready_o;
  logic [16*W-1:0]   blk_data_i;
  logic              blk_last_i;
  logic [7:0]        blk_bytes_i;
  logic              cmp_valid_o;
  logic [8*W-1:0]    cmp_h_o;
  logic [16*W-1:0]   cmp_m_o;
  logic [2*W-1:0]    cmp_t_o;
  logic              cmp_f_o;
  logic [8*W-1:0]    cmp_h_i;
  logic              cmp_valid_i;
  logic              digest_valid_o;
  logic              digest_ready_i;
  logic [8*W-1:0]    digest_o;

  modport slave (
    input  blk_valid_i, blk_data_i, blk_last_i, blk_bytes_i,
    input  cmp_h_i, cmp_valid_i, digest_ready_i,
    output blk_ready_o, cmp_valid_o, cmp_h_o, cmp_m_o, cmp_t_o, cmp_f_o,
    output digest_valid_o, digest_o
  );

  modport master (
    output blk_valid_i, blk_data_i, blk_last_i, blk_bytes_i,
    output cmp_h_i, cmp_valid_i, digest_ready_i,
    input  blk_ready_o, cmp_valid_o, cmp_h_o, cmp_m_o, cmp_t_o, cmp_f_o,
    input  digest_valid_o, digest_o
  );
endinterface

// File: rtl/blake2b_ctrl.sv
// BLAKE2b block sequencer: owns h, t and f, pads the last block, drives one core start per block.
// Optional BLAKE2B_CTRL_PERF_EN adds saturating busy-cycle and start-pulse counters.
module blake2b_ctrl #(
  parameter int W  = 64,
  parameter int NN = 64
) (
  input  logic              clk,
  input  logic              nreset,
  blake2b_ctrl_if.slave     bus
`ifdef BLAKE2B_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_cycles_o,
  output logic [31:0]       perf_blocks_o
`endif
);
  localparam int HW = 8*W;
  localparam int MW = 16*W;
  localparam int TW = 2*W;
  localparam int BLK_BYTES = 2*W;

  // IV words 7..0; word 0 additionally carries the parameter block (fanout=1, depth=1, NN).
  localparam logic [HW-1:0] IV_ALL = 512'h5be0cd19137e2179_1f83d9abfb41bd6b_9b05688c2b3e6c1f_510e527fade682d1_a54ff53a5f1d36f1_3c6ef372fe94f82b_bb67ae8584caa73b_6a09e667f3bcc908;
  localparam logic [HW-1:0] PARAM_WORD = {{(HW-64){1'b0}}, 64'h0000_0000_0101_0000 ^ 64'(NN)};
  localparam logic [HW-1:0] H0 = IV_ALL ^ PARAM_WORD;

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t         state_reg, state_next;
  logic [HW-1:0]  h_reg;
  logic [TW-1:0]  t_reg;
  logic           f_reg;
  logic [MW-1:0]  m_reg;
  logic [HW-1:0]  digest_reg;

  logic           blk_accept;
  logic           result_take;
  logic           digest_take;
  logic [7:0]     n_eff;
  logic [MW-1:0]  m_pad;
  logic [HW-1:0]  digest_mask;

  always_comb begin
    n_eff = 8'(BLK_BYTES);
    if (bus.blk_last_i && (bus.blk_bytes_i < 8'(BLK_BYTES)))
      n_eff = bus.blk_bytes_i;
  end

  for (genvar gi = 0; gi < MW/8; gi++) begin : g_pad
    assign m_pad[gi*8 +: 8] = (n_eff > 8'(gi)) ? bus.blk_data_i[gi*8 +: 8] : 8'h00;
  end

  for (genvar gi = 0; gi < HW/8; gi++) begin : g_mask
    assign digest_mask[gi*8 +: 8] = (gi < NN) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!nreset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    blk_accept  = 1'b0;
    result_take = 1'b0;
    digest_take = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.blk_valid_i) begin
          blk_accept = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (bus.cmp_valid_i) begin
          result_take = 1'b1;
          state_next  = f_reg ? OUT : IDLE;
        end
      end
      OUT: begin
        if (bus.digest_ready_i) begin
          digest_take = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      h_reg      <= H0;
      t_reg      <= '0;
      f_reg      <= 1'b0;
      m_reg      <= '0;
      digest_reg <= '0;
    end else begin
      if (blk_accept) begin
        m_reg <= m_pad;
        t_reg <= t_reg + TW'(n_eff);
        f_reg <= bus.blk_last_i;
      end
      if (result_take) begin
        h_reg <= bus.cmp_h_i;
        if (f_reg) digest_reg <= bus.cmp_h_i & digest_mask;
      end
      if (digest_take) begin
        h_reg      <= H0;
        t_reg      <= '0;
        f_reg      <= 1'b0;
        digest_reg <= '0;
      end
    end
  end

  assign bus.blk_ready_o    = (state_reg == IDLE);
  assign bus.cmp_valid_o    = (state_reg == START);
  assign bus.digest_valid_o = (state_reg == OUT);
  assign bus.cmp_h_o        = h_reg;
  assign bus.cmp_m_o        = m_reg;
  assign bus.cmp_t_o        = t_reg;
  assign bus.cmp_f_o        = f_reg;
  assign bus.digest_o       = digest_reg;

`ifdef BLAKE2B_CTRL_PERF_EN
  logic [31:0] perf_cycles_reg, perf_blocks_reg;

  // Counting on state_next makes the value shown in a cycle include that cycle.
  always_ff @(posedge clk) begin
    if (!nreset || digest_take) begin
      perf_cycles_reg <= '0;
      perf_blocks_reg <= '0;
    end else begin
      if ((state_next != IDLE) && (perf_cycles_reg != '1))
        perf_cycles_reg <= perf_cycles_reg + 32'd1;
      if ((state_reg == START) && (perf_blocks_reg != '1))
        perf_blocks_reg <= perf_blocks_reg + 32'd1;
    end
  end

  assign perf_cycles_o = perf_cycles_reg;
  assign perf_blocks_o = perf_blocks_reg;
`else
  // No performance counters in this build.
`endif
endmodule

// File: tb/tb_blake2b_ctrl.sv
// Self-checking bench for blake2b_ctrl: a behavioural BLAKE2b core plus a byte-level hash model.
module tb_blake2b_ctrl;
  localparam int W  = 64;
  localparam int NN = 64;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  blake2b_ctrl_if #(.W(W)) bus();

  logic         core_valid, man_valid;
  logic [511:0] core_h, man_h;
  assign bus.cmp_valid_i = core_valid | man_valid;
  assign bus.cmp_h_i     = man_valid ? man_h : core_h;

`ifdef BLAKE2B_CTRL_PERF_EN
  logic [31:0] perf_cycles, perf_blocks;
`endif

  blake2b_ctrl #(.W(W), .NN(NN)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus)
`ifdef BLAKE2B_CTRL_PERF_EN
    ,
    .perf_cycles_o(perf_cycles),
    .perf_blocks_o(perf_blocks)
`endif
  );

  int checks = 0;
  int errors = 0;

  bit core_en   = 1'b0;
  bit core_stub = 1'b0;
  int core_lat  = 3;

  logic [7:0]    msg [512];
  logic [511:0]  obs_h [$];
  logic [1023:0] obs_m [$];
  logic [127:0]  obs_t [$];
  bit            obs_f [$];

  logic [63:0] iv [8] = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                          64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                          64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  int sigma [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};
  int ga [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int gb [8] = '{4, 5, 6, 7, 5, 6, 7, 4};
  int gc [8] = '{8, 9,10,11,10,11, 8, 9};
  int gd [8] = '{12,13,14,15,15,12,13,14};

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] h, input logic [1023:0] m,
                                            input logic [127:0] t, input bit f);
    logic [63:0] v [16];
    logic [63:0] mw [16];
    logic [63:0] a, b, c, d, x, y;
    logic [511:0] r;
    for (int i = 0; i < 8; i++) begin
      v[i]   = h[i*64 +: 64];
      v[i+8] = iv[i];
    end
    for (int i = 0; i < 16; i++) mw[i] = m[i*64 +: 64];
    v[12] = v[12] ^ t[63:0];
    v[13] = v[13] ^ t[127:64];
    if (f) v[14] = ~v[14];
    for (int rnd = 0; rnd < 12; rnd++) begin
      for (int j = 0; j < 8; j++) begin
        a = v[ga[j]]; b = v[gb[j]]; c = v[gc[j]]; d = v[gd[j]];
        x = mw[sigma[rnd % 10][2*j]];
        y = mw[sigma[rnd % 10][2*j+1]];
        a = a + b + x; d = rotr(d ^ a, 32); c = c + d; b = rotr(b ^ c, 24);
        a = a + b + y; d = rotr(d ^ a, 16); c = c + d; b = rotr(b ^ c, 63);
        v[ga[j]] = a; v[gb[j]] = b; v[gc[j]] = c; v[gd[j]] = d;
      end
    end
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = h[i*64 +: 64] ^ v[i] ^ v[i+8];
    return r;
  endfunction

  function automatic logic [511:0] core_fn(input logic [511:0] h, input logic [1023:0] m,
                                           input logic [127:0] t, input bit f);
    if (core_stub) return h ^ 512'd1;
    return compress(h, m, t, f);
  endfunction

  function automatic logic [511:0] model_h0();
    logic [511:0] r;
    for (int i = 0; i < 8; i++) r[i*64 +: 64] = iv[i];
    r[63:0] = iv[0] ^ 64'h0101_0000 ^ 64'(NN);
    return r;
  endfunction

  function automatic logic [1023:0] model_block(input int b, input int len);
    logic [1023:0] r;
    int idx;
    for (int k = 0; k < 128; k++) begin
      idx = b*128 + k;
      r[k*8 +: 8] = (idx < len) ? msg[idx] : 8'h00;
    end
    return r;
  endfunction

  function automatic int num_blocks(input int len);
    return (len == 0) ? 1 : (len + 127) / 128;
  endfunction

  // Behavioural core: captures each start, checks the request is held, answers after core_lat cycles.
  initial begin
    logic [511:0]  ch;
    logic [1023:0] cm;
    logic [127:0]  ct;
    bit            cf;
    core_valid = 1'b0;
    core_h     = '0;
    forever begin
      @(posedge clk); #2;
      core_valid = 1'b0;
      if (core_en && bus.cmp_valid_o === 1'b1) begin
        ch = bus.cmp_h_o; cm = bus.cmp_m_o; ct = bus.cmp_t_o; cf = bus.cmp_f_o;
        obs_h.push_back(ch); obs_m.push_back(cm); obs_t.push_back(ct); obs_f.push_back(cf);
        for (int k = 0; k < core_lat; k++) begin
          @(posedge clk); #2;
          checks++;
          if (bus.cmp_h_o !== ch || bus.cmp_m_o !== cm || bus.cmp_t_o !== ct || bus.cmp_f_o !== cf ||
              bus.cmp_valid_o !== 1'b0 || bus.blk_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: start=%b ready=%b t=%0h f=%b h0=%h, required start=0 ready=0 t=%0h f=%b h0=%h",
                     bus.cmp_valid_o, bus.blk_ready_o, bus.cmp_t_o, bus.cmp_f_o, bus.cmp_h_o[63:0], ct, cf, ch[63:0]);
          end
        end
        core_h     = core_fn(ch, cm, ct, cf);
        core_valid = 1'b1;
        @(posedge clk); #2;
        core_valid = 1'b0;
        checks++;
        if (cf && bus.digest_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL digest_latency: digest_valid=%b, required 1", bus.digest_valid_o);
        end else if (!cf && bus.blk_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL idle_latency: blk_ready=%b, required 1", bus.blk_ready_o);
        end
      end
    end
  end

  task automatic drive_block(input int b, input int nblk, input int len);
    logic [1023:0] d;
    int n, idx;
    for (int k = 0; k < 128; k++) begin
      idx = b*128 + k;
      d[k*8 +: 8] = (idx < len) ? msg[idx] : 8'($urandom);
    end
    if (b == nblk - 1) begin
      n = len - b*128;
      if (n == 128 && $urandom_range(0, 1) == 1) n = int'($urandom_range(129, 255));
    end else begin
      n = int'($urandom_range(0, 255));
    end
    bus.blk_valid_i = 1'b1;
    bus.blk_data_i  = d;
    bus.blk_last_i  = (b == nblk - 1);
    bus.blk_bytes_i = 8'(n);
  endtask

  task automatic send_block(input int b, input int nblk, input int len);
    int waited = 0;
    drive_block(b, nblk, len);
    while (bus.blk_ready_o !== 1'b1 && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (bus.blk_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: blk_ready=%b after %0d cycles, required 1", bus.blk_ready_o, waited);
      bus.blk_valid_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.blk_valid_i = 1'b0;
    checks++;
    if (bus.cmp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: cmp_valid=%b, required 1", bus.cmp_valid_o);
    end
  endtask

  task automatic wait_digest(input string name);
    int waited = 0;
    while (bus.digest_valid_o !== 1'b1 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (bus.digest_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_digest_timeout: digest_valid=%b, required 1", name, bus.digest_valid_o);
    end
  endtask

  task automatic send_message(input int len, input string name);
    int nblk = num_blocks(len);
    obs_h.delete(); obs_m.delete(); obs_t.delete(); obs_f.delete();
    for (int b = 0; b < nblk; b++) send_block(b, nblk, len);
    wait_digest(name);
  endtask

  task automatic check_message(input int len, input string name);
    logic [511:0]  h = model_h0();
    logic [1023:0] m;
    logic [127:0]  t;
    logic [511:0]  expd;
    bit            f;
    int            nblk = num_blocks(len);
    checks++;
    if (obs_t.size() != nblk) begin
      errors++;
      $display("FAIL %s_start_count: %0d starts, required %0d", name, obs_t.size(), nblk);
    end
    for (int b = 0; b < nblk; b++) begin
      m = model_block(b, len);
      t = 128'((len < (b+1)*128) ? len : (b+1)*128);
      f = (b == nblk - 1);
      if (b < obs_t.size()) begin
        checks++;
        if (obs_h[b] !== h || obs_m[b] !== m || obs_t[b] !== t || obs_f[b] !== f) begin
          errors++;
          $display("FAIL %s_block%0d: t=%0d f=%b h0=%h m_ok=%b, required t=%0d f=%b h0=%h",
                   name, b, obs_t[b], obs_f[b], obs_h[b][63:0], obs_m[b] === m, t, f, h[63:0]);
        end
      end
      h = core_fn(h, m, t, f);
    end
    expd = h;
    for (int i = 0; i < 64; i++) if (i >= NN) expd[i*8 +: 8] = 8'h00;
    checks++;
    if (bus.digest_o !== expd) begin
      errors++;
      $display("FAIL %s_digest: low word %h, required %h", name, bus.digest_o[63:0], expd[63:0]);
    end
  endtask

  task automatic ack_digest(input string name);
    bus.digest_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready_i = 1'b0;
    checks++;
    if (bus.digest_valid_o !== 1'b0 || bus.blk_ready_o !== 1'b1 || bus.cmp_h_o !== model_h0() ||
        bus.cmp_t_o !== 128'd0 || bus.cmp_f_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: digest_valid=%b ready=%b t=%0d f=%b h0=%h, required 0 1 0 0 %h", name,
               bus.digest_valid_o, bus.blk_ready_o, bus.cmp_t_o, bus.cmp_f_o, bus.cmp_h_o[63:0], model_h0()[63:0]);
    end
  endtask

  task automatic test_reset();
    core_en = 1'b0;
    nreset = 1'b0;
    bus.blk_valid_i = 1'b0; bus.blk_data_i = '0; bus.blk_last_i = 1'b0; bus.blk_bytes_i = '0;
    bus.digest_ready_i = 1'b0;
    man_valid = 1'b0; man_h = '0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.blk_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: %b, required 1", bus.blk_ready_o); end
    checks++;
    if (bus.cmp_valid_o !== 1'b0 || bus.digest_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valids: cmp=%b digest=%b, required 0 0", bus.cmp_valid_o, bus.digest_valid_o);
    end
    checks++;
    if (bus.cmp_h_o[63:0] !== 64'h6A09E667F2BDC948) begin
      errors++; $display("FAIL reset_h0_word0: %h, required 6a09e667f2bdc948", bus.cmp_h_o[63:0]);
    end
    checks++;
    if (bus.cmp_h_o !== model_h0()) begin
      errors++; $display("FAIL reset_h0: word7 %h, required %h", bus.cmp_h_o[511:448], model_h0()[511:448]);
    end
    checks++;
    if (bus.cmp_t_o !== 128'd0 || bus.cmp_f_o !== 1'b0 || bus.cmp_m_o !== '0 || bus.digest_o !== '0) begin
      errors++; $display("FAIL reset_regs: t=%0d f=%b, required t=0 f=0 m=0 digest=0", bus.cmp_t_o, bus.cmp_f_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    core_en = 1'b0;
    for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
    send_block(0, 1, 10);
    @(posedge clk); #1;
    checks++;
    if (bus.blk_ready_o !== 1'b0 || bus.cmp_t_o !== 128'd10 || bus.cmp_f_o !== 1'b1) begin
      errors++; $display("FAIL midwait_state: ready=%b t=%0d f=%b, required 0 10 1", bus.blk_ready_o, bus.cmp_t_o, bus.cmp_f_o);
    end
    nreset = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    checks++;
    if (bus.blk_ready_o !== 1'b1 || bus.cmp_valid_o !== 1'b0 || bus.cmp_t_o !== 128'd0 ||
        bus.cmp_f_o !== 1'b0 || bus.cmp_h_o !== model_h0()) begin
      errors++; $display("FAIL midwait_reset: ready=%b t=%0d f=%b, required ready=1 t=0 f=0 h=h0", bus.blk_ready_o, bus.cmp_t_o, bus.cmp_f_o);
    end
    man_h = {16{32'($urandom)}};
    man_valid = 1'b1;
    @(posedge clk); #1;
    man_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.cmp_h_o !== model_h0() || bus.blk_ready_o !== 1'b1 || bus.digest_valid_o !== 1'b0) begin
      errors++; $display("FAIL stray_result: h0=%h ready=%b digest_valid=%b, required h0 1 0", bus.cmp_h_o[63:0], bus.blk_ready_o, bus.digest_valid_o);
    end
    core_en = 1'b1;
  endtask

  task automatic test_abc();
    logic [511:0] kat, expd;
    core_stub = 1'b0; core_lat = 3;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_message(3, "abc");
    check_message(3, "abc");
    kat  = 512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923;
    expd = {<<8{kat}};
    checks++;
    if (bus.digest_o !== expd) begin
      errors++; $display("FAIL abc_kat: byte0=%h low word %h, required byte0=ba low word %h", bus.digest_o[7:0], bus.digest_o[63:0], expd[63:0]);
    end
    ack_digest("abc");
  endtask

  task automatic test_empty();
    logic [511:0] kat, expd;
    core_stub = 1'b0; core_lat = 1;
    send_message(0, "empty");
    check_message(0, "empty");
    kat  = 512'h786a02f742015903c6c6fd852552d272912f4740e15847618a86e217f71f5419d25e1031afee585313896444934eb04b903a685b1448b755d56f701afe9be2ce;
    expd = {<<8{kat}};
    checks++;
    if (bus.digest_o !== expd) begin
      errors++; $display("FAIL empty_kat: low word %h, required %h", bus.digest_o[63:0], expd[63:0]);
    end
    ack_digest("empty");
  endtask

  task automatic test_three_block_stub();
    core_stub = 1'b1; core_lat = 2;
    for (int i = 0; i < 261; i++) msg[i] = 8'($urandom);
    send_message(261, "three");
    check_message(261, "three");
    ack_digest("three");
    core_stub = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [511:0] d0;
    int len1, len2;
    core_stub = 1'b0; core_lat = 4;
    len1 = int'($urandom_range(1, 200));
    for (int i = 0; i < len1; i++) msg[i] = 8'($urandom);
    send_message(len1, "bp1");
    check_message(len1, "bp1");
    d0 = bus.digest_o;
    len2 = int'($urandom_range(0, 128));
    for (int i = 0; i < len2; i++) msg[i] = 8'($urandom);
    drive_block(0, 1, len2);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.digest_o !== d0 || bus.digest_valid_o !== 1'b1 || bus.blk_ready_o !== 1'b0 || bus.cmp_valid_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold: cycle %0d digest_valid=%b ready=%b start=%b stable=%b, required 1 0 0 1",
                           c, bus.digest_valid_o, bus.blk_ready_o, bus.cmp_valid_o, bus.digest_o === d0);
      end
    end
    obs_h.delete(); obs_m.delete(); obs_t.delete(); obs_f.delete();
    bus.digest_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.digest_ready_i = 1'b0;
    checks++;
    if (bus.blk_ready_o !== 1'b1 || bus.cmp_h_o !== model_h0() || bus.cmp_t_o !== 128'd0) begin
      errors++; $display("FAIL bp_release: ready=%b t=%0d h0=%h, required 1 0 %h", bus.blk_ready_o, bus.cmp_t_o, bus.cmp_h_o[63:0], model_h0()[63:0]);
    end
    @(posedge clk); #1;
    bus.blk_valid_i = 1'b0;
    checks++;
    if (bus.cmp_valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_next_accept: cmp_valid=%b, required 1", bus.cmp_valid_o);
    end
    wait_digest("bp2");
    check_message(len2, "bp2");
    ack_digest("bp2");
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 8; it++) begin
      len = int'($urandom_range(0, 512));
      core_stub = ($urandom_range(0, 3) == 0);
      core_lat  = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
      send_message(len, "random");
      check_message(len, "random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ack_digest("random");
    end
    core_stub = 1'b0;
  endtask

`ifdef BLAKE2B_CTRL_PERF_EN
  task automatic test_perf();
    core_stub = 1'b1; core_lat = 14;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_message(3, "perf");
    checks++;
    if (perf_blocks !== 32'd1) begin errors++; $display("FAIL perf_blocks: %0d, required 1", perf_blocks); end
    checks++;
    if (perf_cycles !== 32'(core_lat + 2)) begin errors++; $display("FAIL perf_cycles: %0d, required %0d", perf_cycles, core_lat + 2); end
    check_message(3, "perf");
    ack_digest("perf");
    checks++;
    if (perf_blocks !== 32'd0 || perf_cycles !== 32'd0) begin
      errors++; $display("FAIL perf_clear: cycles=%0d blocks=%0d, required 0 0", perf_cycles, perf_blocks);
    end
    core_stub = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_abc();
    test_empty();
    test_three_block_stub();
    test_backpressure();
    test_random();
`ifdef BLAKE2B_CTRL_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
